// File: rtl/m_ext_sched_if.sv
// rtl/m_ext_sched_if.sv - EX-stage and M-unit side signal bundle for m_ext_sched
interface m_ext_sched_if #(
    parameter int XLEN = 32
);
    // pipeline side
    logic            i_valid;
    logic            i_flush;
    logic [2:0]      i_f3;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_rs2;
    logic            o_stall;
    logic [XLEN-1:0] o_res;
    // unit side
    logic            o_mul_start;
    logic            o_div_start;
    logic [2:0]      o_f3;
    logic [XLEN-1:0] o_a;
    logic [XLEN-1:0] o_b;
    logic            i_mul_done;
    logic [XLEN-1:0] i_mul_res;
    logic            i_div_done;
    logic [XLEN-1:0] i_div_res;

    modport slave (
        input  i_valid, i_flush, i_f3, i_rs1, i_rs2,
        input  i_mul_done, i_mul_res, i_div_done, i_div_res,
        output o_stall, o_res, o_mul_start, o_div_start, o_f3, o_a, o_b
    );

    modport master (
        output i_valid, i_flush, i_f3, i_rs1, i_rs2,
        output i_mul_done, i_mul_res, i_div_done, i_div_res,
        input  o_stall, o_res, o_mul_start, o_div_start, o_f3, o_a, o_b
    );
endinterface

// File: rtl/m_ext_sched.sv
// rtl/m_ext_sched.sv - MUL/DIV sequencer with special-case bypass, result cache and flush drain
module m_ext_sched #(
    parameter int XLEN     = 32,
    parameter bit CACHE_EN = 1'b1
) (
    input logic          i_clk,
    input logic          i_rst,
    m_ext_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, BUSY, DONE, DRAIN} state_t;

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2:0]      F3_DIV   = 3'b100;
    localparam logic [2:0]      F3_REM   = 3'b110;

    state_t          state, state_nx;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] a_q, b_q, res_q;
    logic            cache_vld;
    logic [2:0]      cache_f3;
    logic [XLEN-1:0] cache_a, cache_b, cache_res;

    logic            special;
    logic [XLEN-1:0] spec_res;
    logic            hit;
    logic            accept;
    logic            done_sel;
    logic [XLEN-1:0] res_sel;

    // Requests answered without a unit: divide by zero, signed overflow, REM x,x
    always_comb begin
        special  = 1'b0;
        spec_res = '0;
        if (bus.i_f3[2] && (bus.i_rs2 == '0)) begin
            special  = 1'b1;
            spec_res = bus.i_f3[1] ? bus.i_rs1 : ALL_ONES;
        end else if ((bus.i_f3 == F3_DIV) && (bus.i_rs1 == MIN_INT) && (bus.i_rs2 == ALL_ONES)) begin
            special  = 1'b1;
            spec_res = MIN_INT;
        end else if ((bus.i_f3 == F3_REM) && (bus.i_rs1 == bus.i_rs2)) begin
            special  = 1'b1;
            spec_res = '0;
        end
    end

    assign hit      = CACHE_EN && cache_vld && (cache_f3 == bus.i_f3) &&
                      (cache_a == bus.i_rs1) && (cache_b == bus.i_rs2);
    assign accept   = (state == IDLE) && bus.i_valid && !bus.i_flush && !special && !hit;
    assign done_sel = f3_q[2] ? bus.i_div_done : bus.i_mul_done;
    assign res_sel  = f3_q[2] ? bus.i_div_res  : bus.i_mul_res;

    assign bus.o_f3 = f3_q;
    assign bus.o_a  = a_q;
    assign bus.o_b  = b_q;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; a flush that coincides with done needs no drain
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   state_nx = bus.i_flush ? IDLE : BUSY;
            BUSY: begin
                if (bus.i_flush)   state_nx = done_sel ? IDLE : DRAIN;
                else if (done_sel) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            DRAIN:   if (done_sel) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs: stall, result mux and start pulses
    always_comb begin
        bus.o_stall     = 1'b0;
        bus.o_res       = res_q;
        bus.o_mul_start = 1'b0;
        bus.o_div_start = 1'b0;
        case (state)
            IDLE: begin
                bus.o_stall = accept;
                if (special)  bus.o_res = spec_res;
                else if (hit) bus.o_res = cache_res;
            end
            ISSUE: begin
                bus.o_stall     = 1'b1;
                bus.o_mul_start = !bus.i_flush && !f3_q[2];
                bus.o_div_start = !bus.i_flush &&  f3_q[2];
            end
            BUSY:    bus.o_stall = 1'b1;
            DRAIN:   bus.o_stall = bus.i_valid;
            default: bus.o_stall = 1'b0;
        endcase
    end

    // Operand latch, result register and single-entry result cache
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            f3_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cache_vld <= 1'b0;
            cache_f3  <= '0;
            cache_a   <= '0;
            cache_b   <= '0;
            cache_res <= '0;
        end else begin
            if (accept) begin
                f3_q <= bus.i_f3;
                a_q  <= bus.i_rs1;
                b_q  <= bus.i_rs2;
            end
            if ((state == BUSY) && done_sel && !bus.i_flush) begin
                res_q <= res_sel;
                if (CACHE_EN) begin
                    cache_vld <= 1'b1;
                    cache_f3  <= f3_q;
                    cache_a   <= a_q;
                    cache_b   <= b_q;
                    cache_res <= res_sel;
                end
            end
        end
    end
endmodule
